parallel_bus_slave_burst: RTL and testbench

//  Parametrised slave for the 4-wire-control parallel bus (bus/read/register_select/enable/ack_valid).

---
 rtl/parallel_bus_slave_burst.sv | 174 +++++++++++++++++
 tb/tb_parallel_bus_slave_burst.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_bus_slave_burst.sv
// rtl/parallel_bus_slave_burst.sv - multi-beat parallel bus slave with four-phase handshake, burst addressing and read prefetch
module parallel_bus_slave_burst #(
  parameter int BUS_WIDTH         = 8,
  parameter int BEATS_PER_DATA    = 2,
  parameter int BEATS_PER_ADDRESS = 2,
  parameter int ADDRESS_DEPTH     = 14,
  parameter int AUTO_INCREMENT    = 1,
  parameter int SYNC_STAGES       = 2,
  localparam int DATA_W           = BEATS_PER_DATA * BUS_WIDTH
) (
  input  logic                     clock50,
  input  logic                     reset,
  input  logic [BUS_WIDTH-1:0]     bus_in,
  output logic [BUS_WIDTH-1:0]     bus_out,
  output logic                     bus_oe,
  input  logic                     read,
  input  logic                     register_select,
  input  logic                     enable,
  output logic                     ack_valid,
  output logic [ADDRESS_DEPTH-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [15:0]              errors
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int ADDR_W = BEATS_PER_ADDRESS * BUS_WIDTH;
  localparam int DB_W   = (BEATS_PER_DATA > 1) ? $clog2(BEATS_PER_DATA) : 1;
  localparam int AB_W   = (BEATS_PER_ADDRESS > 1) ? $clog2(BEATS_PER_ADDRESS) : 1;
  localparam logic [DB_W-1:0] D_MSB = DB_W'(BEATS_PER_DATA - 1);
  localparam logic [AB_W-1:0] A_MSB = AB_W'(BEATS_PER_ADDRESS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ACK} state_t;

  state_t state, state_next;

  logic [SYNC_N-1:0]    read_sync, rs_sync, en_sync;
  logic [BUS_WIDTH-1:0] bus_sync [SYNC_N];
  logic                 read_s, rs_s, en_s;
  logic [BUS_WIDTH-1:0] bus_s;

  logic [ADDR_W-1:0] addr_reg, addr_asm;
  logic [DATA_W-1:0] wdata_reg, wdata_asm, rd_word;
  logic [AB_W-1:0]   abeat;
  logic [DB_W-1:0]   dbeat, rbeat, dbeat_eff, rbeat_eff;
  logic              rd_valid, fetch_cnt;
  logic              wr_addr, wr_data, rd_data, flip_err, addr_err;

  always_ff @(posedge clock50) begin
    if (reset) begin
      read_sync <= '0;
      rs_sync   <= '0;
      en_sync   <= '0;
      for (int i = 0; i < SYNC_N; i++) bus_sync[i] <= '0;
    end else begin
      read_sync   <= {read_sync[SYNC_N-2:0], read};
      rs_sync     <= {rs_sync[SYNC_N-2:0], register_select};
      en_sync     <= {en_sync[SYNC_N-2:0], enable};
      bus_sync[0] <= bus_in;
      for (int i = 1; i < SYNC_N; i++) bus_sync[i] <= bus_sync[i-1];
    end
  end

  assign read_s = read_sync[SYNC_N-1];
  assign rs_s   = rs_sync[SYNC_N-1];
  assign en_s   = en_sync[SYNC_N-1];
  assign bus_s  = bus_sync[SYNC_N-1];

  assign bus_oe    = read_s;
  assign ack_valid = (state == ACK);

  always_ff @(posedge clock50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (en_s) state_next = (read_s && rs_s && !rd_valid) ? FETCH : EXEC;
      FETCH: if (fetch_cnt) state_next = EXEC;
      EXEC:  state_next = ACK;
      ACK:   if (!en_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A beat of the other direction while a word is half transferred is a protocol error;
  // both beat counters restart and the current beat is taken as the first of a new word.
  always_comb begin
    wr_addr   = !rs_s && !read_s;
    wr_data   = rs_s && !read_s;
    rd_data   = rs_s && read_s;
    flip_err  = (wr_data && rbeat != D_MSB) || (rd_data && dbeat != D_MSB);
    addr_err  = wr_addr && dbeat != D_MSB;
    dbeat_eff = (flip_err || addr_err) ? D_MSB : dbeat;
    rbeat_eff = flip_err ? D_MSB : rbeat;
    addr_asm  = addr_reg;
    addr_asm[int'(abeat)*BUS_WIDTH +: BUS_WIDTH] = bus_s;
    wdata_asm = wdata_reg;
    wdata_asm[int'(dbeat_eff)*BUS_WIDTH +: BUS_WIDTH] = bus_s;
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      bus_out   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      errors    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_word   <= '0;
      abeat     <= A_MSB;
      dbeat     <= D_MSB;
      rbeat     <= D_MSB;
      rd_valid  <= 1'b0;
      fetch_cnt <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      fetch_cnt <= (state == FETCH) && !fetch_cnt;

      // Post-write increment lands after the strobe so the memory sees the old address.
      if (mem_we && AUTO_INCREMENT != 0) mem_addr <= mem_addr + ADDRESS_DEPTH'(1);

      if (state == FETCH && fetch_cnt) begin
        rd_word  <= mem_rdata;
        rd_valid <= 1'b1;
      end

      if (state == EXEC) begin
        if ((flip_err || addr_err) && errors != 16'hFFFF) errors <= errors + 16'd1;

        if (wr_addr) begin
          addr_reg <= addr_asm;
          dbeat    <= dbeat_eff;
          if (abeat == '0) begin
            abeat    <= A_MSB;
            mem_addr <= addr_asm[ADDRESS_DEPTH-1:0];
            rd_valid <= 1'b0;
            rbeat    <= D_MSB;
          end else begin
            abeat <= abeat - AB_W'(1);
          end
        end else if (wr_data) begin
          wdata_reg <= wdata_asm;
          rd_valid  <= 1'b0;
          rbeat     <= rbeat_eff;
          if (dbeat_eff == '0) begin
            mem_wdata <= wdata_asm;
            mem_we    <= 1'b1;
            dbeat     <= D_MSB;
          end else begin
            dbeat <= dbeat_eff - DB_W'(1);
          end
        end else if (rd_data) begin
          bus_out <= rd_word[int'(rbeat_eff)*BUS_WIDTH +: BUS_WIDTH];
          dbeat   <= dbeat_eff;
          if (rbeat_eff == '0) begin
            rbeat    <= D_MSB;
            rd_valid <= 1'b0;
            if (AUTO_INCREMENT != 0) mem_addr <= mem_addr + ADDRESS_DEPTH'(1);
          end else begin
            rbeat <= rbeat_eff - DB_W'(1);
          end
        end else begin
          bus_out <= BUS_WIDTH'(errors);
        end
      end
    end
  end

endmodule

// File: tb/tb_parallel_bus_slave_burst.sv
// tb/tb_parallel_bus_slave_burst.sv - directed self-checking bench for parallel_bus_slave_burst
module tb_parallel_bus_slave_burst;

  logic        clock50 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_in = '0;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        read = 1'b0;
  logic        register_select = 1'b0;
  logic        enable = 1'b0;
  logic        ack_valid;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;
  logic [15:0] errors;

  int checks = 0;
  int n_err = 0;
  int we_count = 0;
  logic [13:0] we_addr = '0;
  logic [31:0] we_data = '0;
  logic [31:0] mem [0:16383];

  always #5 clock50 = ~clock50;

  parallel_bus_slave_burst #(
    .BUS_WIDTH(16), .BEATS_PER_DATA(2), .BEATS_PER_ADDRESS(2),
    .ADDRESS_DEPTH(14), .AUTO_INCREMENT(1), .SYNC_STAGES(2)
  ) dut (
    .clock50(clock50), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .read(read), .register_select(register_select), .enable(enable), .ack_valid(ack_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .errors(errors)
  );

  always @(posedge clock50) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
      we_addr  <= mem_addr;
      we_data  <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic start_beat(input logic rd, input logic rs, input logic [15:0] din,
                            output logic [15:0] dout, output int lat);
    @(negedge clock50);
    read = rd; register_select = rs; bus_in = din; enable = 1'b1;
    lat = 0;
    do begin @(negedge clock50); lat++; end while (!ack_valid && lat < 50);
    checks++;
    if (ack_valid !== 1'b1) begin
      n_err++; $display("FAIL ack_rise: ack_valid=%b after %0d cycles, required 1", ack_valid, lat);
    end
    dout = bus_out;
  endtask

  task automatic end_beat();
    int n;
    enable = 1'b0;
    n = 0;
    do begin @(negedge clock50); n++; end while (ack_valid && n < 50);
    checks++;
    if (ack_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_fall: ack_valid=%b after %0d cycles, required 0", ack_valid, n);
    end
  endtask

  task automatic beat(input logic rd, input logic rs, input logic [15:0] din,
                      output logic [15:0] dout, output int lat);
    start_beat(rd, rs, din, dout, lat);
    end_beat();
  endtask

  task automatic write_addr(input logic [31:0] a);
    logic [15:0] d; int l;
    beat(1'b0, 1'b0, a[31:16], d, l);
    beat(1'b0, 1'b0, a[15:0], d, l);
  endtask

  task automatic write_word(input logic [31:0] w);
    logic [15:0] d; int l;
    beat(1'b0, 1'b1, w[31:16], d, l);
    beat(1'b0, 1'b1, w[15:0], d, l);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; read = 1'b0; register_select = 1'b0; bus_in = '0;
    repeat (3) @(negedge clock50);
    reset = 1'b0;
    @(negedge clock50);
    checks++;
    if ({bus_out, bus_oe, ack_valid, mem_we} !== 19'h0) begin
      n_err++; $display("FAIL reset_ctrl: bus_out=%h oe=%b ack=%b we=%b, required all 0", bus_out, bus_oe, ack_valid, mem_we);
    end
    checks++;
    if (mem_addr !== 14'h0 || mem_wdata !== 32'h0 || errors !== 16'h0) begin
      n_err++; $display("FAIL reset_data: addr=%h wdata=%h errors=%h, required 0", mem_addr, mem_wdata, errors);
    end
  endtask

  task automatic test_single_write();
    logic [15:0] d; int l; int w0;
    beat(1'b0, 1'b0, 16'h0000, d, l);
    checks++;
    if (l !== 4) begin n_err++; $display("FAIL latency_plain: %0d cycles, required 4", l); end
    beat(1'b0, 1'b0, 16'h2B4C, d, l);
    checks++;
    if (mem_addr !== 14'h2B4C) begin n_err++; $display("FAIL addr_load: %h, required 2b4c", mem_addr); end
    w0 = we_count;
    write_word(32'h3123_2A12);
    checks++;
    if (we_count !== w0 + 1) begin n_err++; $display("FAIL single_we_count: %0d, required %0d", we_count, w0 + 1); end
    checks++;
    if (we_addr !== 14'h2B4C || we_data !== 32'h3123_2A12) begin
      n_err++; $display("FAIL single_write: addr=%h data=%h, required 2b4c 31232a12", we_addr, we_data);
    end
    checks++;
    if (mem_addr !== 14'h2B4D) begin n_err++; $display("FAIL single_inc: %h, required 2b4d", mem_addr); end
  endtask

  task automatic test_burst();
    logic [31:0] words [4];
    logic [15:0] d; int l; int w0;
    words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    write_addr(32'h0000_0010);
    w0 = we_count;
    for (int i = 0; i < 4; i++) write_word(words[i]);
    checks++;
    if (we_count !== w0 + 4 || mem_addr !== 14'h0014) begin
      n_err++; $display("FAIL burst_write: writes=%0d addr=%h, required %0d 0014", we_count - w0, mem_addr, 4);
    end
    write_addr(32'h0000_0010);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = words[i / 2];
      beat(1'b1, 1'b1, 16'h0000, d, l);
      checks++;
      if (d !== ((i % 2 == 0) ? w[31:16] : w[15:0])) begin
        n_err++; $display("FAIL burst_read%0d: %h, required %h", i, d, (i % 2 == 0) ? w[31:16] : w[15:0]);
      end
      if (i < 2) begin
        checks++;
        if (l !== ((i == 0) ? 6 : 4)) begin n_err++; $display("FAIL latency_read%0d: %0d cycles, required %0d", i, l, (i == 0) ? 6 : 4); end
      end
    end
    checks++;
    if (mem_addr !== 14'h0014) begin n_err++; $display("FAIL burst_read_end: %h, required 0014", mem_addr); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [4];
    logic [15:0] d; int l;
    exp = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
    write_addr(32'h0000_3FFF);
    write_word(32'hDEAD_BEEF);
    checks++;
    if (mem_addr !== 14'h0000) begin n_err++; $display("FAIL wrap_write: %h, required 0000", mem_addr); end
    write_word(32'hCAFE_F00D);
    write_addr(32'h0000_3FFF);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1'b1, 16'h0000, d, l);
      checks++;
      if (d !== exp[i]) begin n_err++; $display("FAIL wrap_read%0d: %h, required %h", i, d, exp[i]); end
    end
    checks++;
    if (mem_addr !== 14'h0001) begin n_err++; $display("FAIL wrap_read_end: %h, required 0001", mem_addr); end
  endtask

  task automatic test_partial_error();
    logic [15:0] d; int l; int w0;
    w0 = we_count;
    beat(1'b0, 1'b1, 16'h1234, d, l);
    write_addr(32'h0000_0020);
    checks++;
    if (errors !== 16'd1 || we_count !== w0) begin
      n_err++; $display("FAIL partial_err: errors=%0d writes=%0d, required 1 0", errors, we_count - w0);
    end
    write_word(32'hABCD_5678);
    checks++;
    if (we_count !== w0 + 1 || we_data !== 32'hABCD_5678 || we_addr !== 14'h0020) begin
      n_err++; $display("FAIL partial_recover: writes=%0d data=%h addr=%h, required 1 abcd5678 0020", we_count - w0, we_data, we_addr);
    end
  endtask

  task automatic test_mode_flip();
    logic [15:0] d; int l; int w0;
    write_addr(32'h0000_0010);
    beat(1'b1, 1'b1, 16'h0000, d, l);
    checks++;
    if (d !== 16'h1111) begin n_err++; $display("FAIL flip_read: %h, required 1111", d); end
    w0 = we_count;
    write_word(32'h9999_8888);
    checks++;
    if (errors !== 16'd2 || we_count !== w0 + 1 || we_data !== 32'h9999_8888 || we_addr !== 14'h0010) begin
      n_err++; $display("FAIL flip_write: errors=%0d writes=%0d data=%h addr=%h, required 2 1 99998888 0010",
                        errors, we_count - w0, we_data, we_addr);
    end
  endtask

  task automatic test_enable_hold();
    logic [15:0] d; int l; int w0; int bad;
    write_addr(32'h0000_0030);
    w0 = we_count;
    start_beat(1'b0, 1'b1, 16'h0102, d, l);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock50);
      if (ack_valid !== 1'b1 || we_count !== w0) bad++;
    end
    checks++;
    if (bad !== 0) begin n_err++; $display("FAIL hold_one_beat: %0d bad cycles, required 0", bad); end
    end_beat();
    beat(1'b0, 1'b1, 16'h0304, d, l);
    checks++;
    if (we_count !== w0 + 1 || we_data !== 32'h0102_0304 || we_addr !== 14'h0030) begin
      n_err++; $display("FAIL hold_word: writes=%0d data=%h addr=%h, required 1 01020304 0030", we_count - w0, we_data, we_addr);
    end
    start_beat(1'b1, 1'b0, 16'h0000, d, l);
    checks++;
    if (d !== 16'h0002 || bus_oe !== 1'b1 || l !== 4) begin
      n_err++; $display("FAIL status_read: bus_out=%h oe=%b lat=%0d, required 0002 1 4", d, bus_oe, l);
    end
    end_beat();
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; int l; int w0;
    write_addr(32'h0000_0040);
    w0 = we_count;
    beat(1'b0, 1'b1, 16'hAAAA, d, l);
    @(negedge clock50);
    reset = 1'b1;
    repeat (2) @(negedge clock50);
    reset = 1'b0;
    checks++;
    if ({bus_out, bus_oe, ack_valid, mem_we} !== 19'h0 || mem_addr !== 14'h0 || mem_wdata !== 32'h0 || errors !== 16'h0) begin
      n_err++; $display("FAIL reset_mid: out=%h oe=%b ack=%b we=%b addr=%h wdata=%h errors=%h, required all 0",
                        bus_out, bus_oe, ack_valid, mem_we, mem_addr, mem_wdata, errors);
    end
    repeat (10) @(negedge clock50);
    checks++;
    if (we_count !== w0) begin n_err++; $display("FAIL reset_no_we: writes=%0d, required 0", we_count - w0); end
    write_addr(32'h0000_0040);
    write_word(32'h5555_6666);
    checks++;
    if (we_count !== w0 + 1 || we_data !== 32'h5555_6666 || we_addr !== 14'h0040) begin
      n_err++; $display("FAIL reset_recover: writes=%0d data=%h addr=%h, required 1 55556666 0040", we_count - w0, we_data, we_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_wrap();
    test_partial_error();
    test_mode_flip();
    test_enable_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, n_err);
    $finish;
  end

endmodule
